// File: rtl/cpu_pkg.sv
// cpu_pkg - shared definitions for the CPU sequencer slice.
//   state_e         : sequencer FSM state encoding (visible on the debug port)
//   CLS_*           : decoder instruction-class encoding
//   PC_W_DEFAULT    : default program-counter / address width
//   normalize_class : folds unused class codes onto NOP
package cpu_pkg;

  localparam int PC_W_DEFAULT = 32;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [2:0] CLS_NOP = 3'd0;
  localparam logic [2:0] CLS_ALU = 3'd1;
  localparam logic [2:0] CLS_LDR = 3'd2;
  localparam logic [2:0] CLS_STR = 3'd3;
  localparam logic [2:0] CLS_B   = 3'd4;
  localparam logic [2:0] CLS_BL  = 3'd5;

  // Codes 6 and 7 are unassigned by the decoder and behave as NOP.
  function automatic logic [2:0] normalize_class(input logic [2:0] cls);
    return (cls > CLS_BL) ? CLS_NOP : cls;
  endfunction

endpackage

// File: rtl/cpu_branch_target.sv
// cpu_branch_target - combinational next-PC adders.
//   pc_i        : current instruction address
//   br_offset_i : signed 24-bit word offset
//   pc_plus4_o  : sequential successor / return address (pc+4)
//   target_o    : branch target pc + 8 + (sext(offset) << 2), wrapping mod 2^PC_W
// PC_W must be at least 24.
module cpu_branch_target
  import cpu_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [23:0]     br_offset_i,
  output logic [PC_W-1:0] pc_plus4_o,
  output logic [PC_W-1:0] target_o
);

  logic [PC_W-1:0] offsetBytes;

  // Word offset is sign-extended to the PC width, then scaled to bytes.
  assign offsetBytes = {{(PC_W-24){br_offset_i[23]}}, br_offset_i} << 2;
  assign pc_plus4_o  = pc_i + PC_W'(4);
  assign target_o    = pc_i + PC_W'(8) + offsetBytes;

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer - multi-cycle control FSM for the single-issue CPU datapath.
// Owns the PC and produces per-phase enables as a Moore decode of the
// registered state and the class latched in DECODE.
//   clk, nreset          : clock, synchronous active-low reset
//   instr_class, set_flags, cond_pass, br_offset : decoder fields (sampled in DECODE)
//   imem_ready, dmem_ready : memory handshakes (FETCH / MEM wait-states)
//   halt_req             : halt after the instruction retiring this cycle
//   instr_en .. lr_we    : phase enables; lr_data is the BL return address
//   pc, state, halted    : current PC, debug state, HALT indicator
//   err                  : sticky wait timeout abort
// Build option SEQ_TIMEOUT_EN: adds a 4-bit wait counter; a FETCH/MEM wait that
// reaches MEM_TIMEOUT cycles sets err and halts. Without it err is tied 0.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W        = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [2:0]      instr_class,
  input  logic            set_flags,
  input  logic            cond_pass,
  input  logic [23:0]     br_offset,
  input  logic            imem_ready,
  input  logic            dmem_ready,
  input  logic            halt_req,
  output logic            instr_en,
  output logic            read_en,
  output logic            alu_en,
  output logic            cpsr_en,
  output logic            mem_en,
  output logic            mem_we,
  output logic            wb_en,
  output logic            lr_we,
  output logic [PC_W-1:0] lr_data,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      state,
  output logic            halted,
  output logic            err
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [2:0]      class_q, class_d;
  logic            sflag_q, sflag_d;
  logic [23:0]     off_q, off_d;
  logic [PC_W-1:0] pcPlus4, branchTarget;
  logic            timeout;

  // The branch target always uses the latched offset; only B/BL ever select it.
  cpu_branch_target #(.PC_W(PC_W)) uBranchTarget (
    .pc_i        (pc_q),
    .br_offset_i (off_q),
    .pc_plus4_o  (pcPlus4),
    .target_o    (branchTarget)
  );

`ifdef SEQ_TIMEOUT_EN
  logic [3:0] waitCnt_q, waitCnt_d;
  logic       err_q;
  logic       waiting;

  // Counter only advances while stalled; any other cycle zeroes it, so it is
  // clear whenever FETCH or MEM is freshly entered.
  assign waiting   = ((state_q == ST_FETCH) && !imem_ready) ||
                     ((state_q == ST_MEM)   && !dmem_ready);
  assign timeout   = waiting && (waitCnt_q == 4'(MEM_TIMEOUT - 1));
  assign waitCnt_d = waiting ? waitCnt_q + 4'd1 : 4'd0;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      waitCnt_q <= 4'd0;
      err_q     <= 1'b0;
    end else begin
      waitCnt_q <= waitCnt_d;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // State register and the architectural latches it owns.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      class_q <= CLS_NOP;
      sflag_q <= 1'b0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      class_q <= class_d;
      sflag_q <= sflag_d;
      off_q   <= off_d;
    end
  end

  // Next-state logic. Every path that completes an instruction raises
  // 'retire'; the PC update and the halt decision are applied in one place.
  always_comb begin
    logic retire;
    logic takeBranch;
    state_d    = state_q;
    pc_d       = pc_q;
    class_d    = class_q;
    sflag_d    = sflag_q;
    off_d      = off_q;
    retire     = 1'b0;
    takeBranch = 1'b0;
    case (state_q)
      ST_FETCH: if (imem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        class_d = normalize_class(instr_class);
        sflag_d = set_flags;
        off_d   = br_offset;
        if (!cond_pass || (class_d == CLS_NOP)) retire = 1'b1;
        else state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (class_q)
          CLS_LDR, CLS_STR: state_d = ST_MEM;
          CLS_B: begin
            retire     = 1'b1;
            takeBranch = 1'b1;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (dmem_ready) begin
          if (class_q == CLS_STR) retire = 1'b1;
          else state_d = ST_WB;
        end
      end
      ST_WB: begin
        retire     = 1'b1;
        takeBranch = (class_q == CLS_BL);
      end
      default: state_d = ST_HALT;
    endcase
    if (timeout) state_d = ST_HALT;
    if (retire) begin
      pc_d    = takeBranch ? branchTarget : pcPlus4;
      state_d = halt_req ? ST_HALT : ST_FETCH;
    end
  end

  // Moore output decode: registered state plus latched class only.
  always_comb begin
    instr_en = 1'b0;
    read_en  = 1'b0;
    alu_en   = 1'b0;
    cpsr_en  = 1'b0;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    wb_en    = 1'b0;
    lr_we    = 1'b0;
    halted   = 1'b0;
    case (state_q)
      ST_FETCH:  instr_en = 1'b1;
      ST_DECODE: read_en = 1'b1;
      ST_EXEC: begin
        alu_en  = 1'b1;
        cpsr_en = sflag_q && (class_q == CLS_ALU);
      end
      ST_MEM: begin
        mem_en = 1'b1;
        mem_we = (class_q == CLS_STR);
      end
      ST_WB: begin
        wb_en = (class_q == CLS_ALU) || (class_q == CLS_LDR);
        lr_we = (class_q == CLS_BL);
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign lr_data = pcPlus4;
  assign pc      = pc_q;
  assign state   = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer - self-checking bench for cpu_sequencer.
// Each instruction is expanded into the list of phases it should visit, derived
// from the per-class latency rules; the DUT is checked against that list every
// cycle, with decoder fields scrambled outside DECODE and halt_req scrambled
// outside the retire cycle. Also covers SEQ_TIMEOUT_EN when that macro is set.
module tb_cpu_sequencer;

  localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC = 2, P_MEM = 3, P_WB = 4, P_HALT = 5;
  localparam logic [2:0] C_NOP = 3'd0, C_ALU = 3'd1, C_LDR = 3'd2, C_STR = 3'd3,
                         C_B = 3'd4, C_BL = 3'd5;

  logic        clk, nreset;
  logic [2:0]  instr_class;
  logic        set_flags, cond_pass, imem_ready, dmem_ready, halt_req;
  logic [23:0] br_offset;
  logic        instr_en, read_en, alu_en, cpsr_en, mem_en, mem_we, wb_en, lr_we;
  logic [31:0] lr_data, pc;
  logic [2:0]  state;
  logic        halted, err;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] modelPc;

  cpu_sequencer #(.PC_W(32), .RESET_PC(32'h0), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .nreset(nreset), .instr_class(instr_class), .set_flags(set_flags),
    .cond_pass(cond_pass), .br_offset(br_offset), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .halt_req(halt_req), .instr_en(instr_en),
    .read_en(read_en), .alu_en(alu_en), .cpsr_en(cpsr_en), .mem_en(mem_en),
    .mem_we(mem_we), .wb_en(wb_en), .lr_we(lr_we), .lr_data(lr_data), .pc(pc),
    .state(state), .halted(halted), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic scrambleInputs();
    instr_class = 3'($urandom);
    set_flags   = 1'($urandom);
    cond_pass   = 1'($urandom);
    br_offset   = 24'($urandom);
    imem_ready  = 1'($urandom);
    dmem_ready  = 1'($urandom);
    halt_req    = 1'($urandom);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold reset for two edges, check the reset state, release at a negedge.
  task automatic doReset();
    nreset = 1'b0;
    scrambleInputs();
    nextCycle();
    nextCycle();
    checkOutput("rst_state", 32'(state), P_FETCH);
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_instr_en", 32'(instr_en), 1);
    checkOutput("rst_enables", 32'({read_en, alu_en, cpsr_en, mem_en, wb_en, lr_we}), 0);
    checkOutput("rst_halted", 32'(halted), 0);
    checkOutput("rst_err", 32'(err), 0);
    nreset  = 1'b1;
    modelPc = 32'h0;
  endtask

  // Runs one instruction from FETCH to retire, with iw imem and dw dmem wait-states.
  task automatic applyStimulus(input logic [2:0] cls, input logic sf, input logic cp,
                               input logic [23:0] off, input int iw, input int dw,
                               input logic haltEnd);
    int          phases[$];
    logic [2:0]  eff;
    logic        branch;
    int          fetchIdx, memIdx, ph;
    logic [31:0] offBytes;
    eff = (cls > C_BL) ? C_NOP : cls;
    for (int k = 0; k <= iw; k++) phases.push_back(P_FETCH);
    phases.push_back(P_DECODE);
    if (cp && eff != C_NOP) begin
      phases.push_back(P_EXEC);
      if (eff == C_LDR || eff == C_STR)
        for (int k = 0; k <= dw; k++) phases.push_back(P_MEM);
      if (eff == C_ALU || eff == C_LDR || eff == C_BL) phases.push_back(P_WB);
    end
    branch   = cp && (eff == C_B || eff == C_BL);
    fetchIdx = 0;
    memIdx   = 0;
    for (int j = 0; j < phases.size(); j++) begin
      ph = phases[j];
      scrambleInputs();
      if (ph == P_DECODE) begin
        instr_class = cls;
        set_flags   = sf;
        cond_pass   = cp;
        br_offset   = off;
      end
      if (ph == P_FETCH) begin
        imem_ready = (fetchIdx < iw) ? 1'b0 : 1'b1;
        fetchIdx++;
      end
      if (ph == P_MEM) begin
        dmem_ready = (memIdx < dw) ? 1'b0 : 1'b1;
        memIdx++;
      end
      halt_req = (j == phases.size() - 1) ? haltEnd : 1'($urandom);
      checkOutput("state", 32'(state), ph);
      checkOutput("pc", pc, modelPc);
      checkOutput("instr_en", 32'(instr_en), 32'(ph == P_FETCH));
      checkOutput("read_en", 32'(read_en), 32'(ph == P_DECODE));
      checkOutput("alu_en", 32'(alu_en), 32'(ph == P_EXEC));
      checkOutput("cpsr_en", 32'(cpsr_en), 32'(ph == P_EXEC && sf && eff == C_ALU));
      checkOutput("mem_en", 32'(mem_en), 32'(ph == P_MEM));
      if (ph == P_MEM) checkOutput("mem_we", 32'(mem_we), 32'(eff == C_STR));
      checkOutput("wb_en", 32'(wb_en), 32'(ph == P_WB && (eff == C_ALU || eff == C_LDR)));
      checkOutput("lr_we", 32'(lr_we), 32'(ph == P_WB && eff == C_BL));
      if (ph == P_WB && eff == C_BL) checkOutput("lr_data", lr_data, modelPc + 32'd4);
      checkOutput("halted", 32'(halted), 0);
      checkOutput("err", 32'(err), 0);
      nextCycle();
    end
    offBytes = {{8{off[23]}}, off} << 2;
    modelPc  = branch ? modelPc + 32'd8 + offBytes : modelPc + 32'd4;
    checkOutput("retire_pc", pc, modelPc);
    checkOutput("retire_state", 32'(state), haltEnd ? P_HALT : P_FETCH);
  endtask

  task automatic checkHalted(input int n);
    for (int k = 0; k < n; k++) begin
      scrambleInputs();
      checkOutput("halt_state", 32'(state), P_HALT);
      checkOutput("halt_flag", 32'(halted), 1);
      checkOutput("halt_pc", pc, modelPc);
      checkOutput("halt_enables",
                  32'({instr_en, read_en, alu_en, cpsr_en, mem_en, wb_en, lr_we}), 0);
      nextCycle();
    end
  endtask

  initial begin
    nreset = 1'b0;
    scrambleInputs();
    @(negedge clk);

    // ALU with flags, no waits, then LDR with three data wait-states.
    doReset();
    applyStimulus(C_ALU, 1'b1, 1'b1, 24'h0, 0, 0, 1'b0);
    applyStimulus(C_LDR, 1'b0, 1'b1, 24'h0, 0, 3, 1'b0);
    applyStimulus(C_STR, 1'b0, 1'b1, 24'h0, 2, 1, 1'b0);

    // B at 0x10: offset -2 lands on itself, offset +2 lands on 0x20.
    doReset();
    repeat (4) applyStimulus(C_NOP, 1'b0, 1'b1, 24'h0, 0, 0, 1'b0);
    applyStimulus(C_B, 1'b1, 1'b1, 24'hFFFFFE, 0, 0, 1'b0);
    applyStimulus(C_B, 1'b0, 1'b1, 24'h000002, 0, 0, 1'b0);

    // BL at 0x8 with offset 1: link 0xC, target 0x14.
    doReset();
    repeat (2) applyStimulus(C_NOP, 1'b0, 1'b1, 24'h0, 0, 0, 1'b0);
    applyStimulus(C_BL, 1'b0, 1'b1, 24'h000001, 0, 0, 1'b0);

    // Condition-failed STR and an unused class, then halt on the next retire.
    doReset();
    applyStimulus(C_STR, 1'b1, 1'b0, 24'h123456, 0, 0, 1'b0);
    applyStimulus(3'd7, 1'b1, 1'b1, 24'h000010, 1, 0, 1'b0);
    applyStimulus(C_NOP, 1'b0, 1'b1, 24'h0, 0, 0, 1'b1);
    checkHalted(10);

    // Reset while an LDR is stalled in MEM.
    doReset();
    applyStimulus(C_NOP, 1'b0, 1'b1, 24'h0, 0, 0, 1'b0);
    instr_class = C_LDR;
    set_flags   = 1'b0;
    cond_pass   = 1'b1;
    br_offset   = 24'h0;
    imem_ready  = 1'b1;
    dmem_ready  = 1'b0;
    halt_req    = 1'b0;
    repeat (4) nextCycle();
    checkOutput("abort_pre_state", 32'(state), P_MEM);
    checkOutput("abort_pre_mem_en", 32'(mem_en), 1);
    nreset = 1'b0;
    nextCycle();
    checkOutput("abort_state", 32'(state), P_FETCH);
    checkOutput("abort_pc", pc, 32'h0);
    checkOutput("abort_mem_en", 32'(mem_en), 0);
    nreset  = 1'b1;
    modelPc = 32'h0;

`ifdef SEQ_TIMEOUT_EN
    // Data memory never answers: 15 wait cycles in MEM, then error halt.
    doReset();
    instr_class = C_LDR;
    cond_pass   = 1'b1;
    imem_ready  = 1'b1;
    dmem_ready  = 1'b0;
    halt_req    = 1'b0;
    repeat (3) nextCycle();
    for (int k = 0; k < 15; k++) begin
      checkOutput("to_wait_state", 32'(state), P_MEM);
      nextCycle();
    end
    checkOutput("to_state", 32'(state), P_HALT);
    checkOutput("to_err", 32'(err), 1);
    checkOutput("to_pc", pc, modelPc);
`endif

    // Random instruction stream ending in a halt.
    doReset();
    for (int n = 0; n < 40; n++) begin
      applyStimulus(3'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                    24'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end
    applyStimulus(3'($urandom), 1'($urandom), 1'b1, 24'($urandom),
                  $urandom_range(0, 2), $urandom_range(0, 2), 1'b1);
    checkHalted(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
